core_flow_ctrl_n: RTL

//  Parametrised core control-flow sequencer: owns the fetch PC redirect, pipeline stall and global flush.

---
 rtl/core_flow_ctrl_n.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/core_flow_ctrl_n.sv
// Core control-flow sequencer: fetch PC redirect, dispatch stall and global flush
// with halt/drain handling, a drain timeout and saturating event counters.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// REDIR  | offering r_pc to fetch until it is accepted
// RUN    | fetching and dispatching
// FLUSH  | one-cycle global flush after a commit redirect
// DRAIN  | waiting for FE/RSV/ROB to empty, bounded by the drain timer
// HDRAIN | halt requested: fetch stopped, waiting for the pipe to empty
// HALTED | quiesced until halt_req drops
module core_flow_ctrl_n #(
    parameter int                NUM_FE    = 3,
    parameter int                NUM_RSV   = 4,
    parameter int                PC_W      = 32,
    parameter logic [PC_W-1:0]   RESET_PC  = '0,
    parameter logic [PC_W-1:0]   EXC_VEC   = PC_W'(32'h100),
    parameter int                DRAIN_TMO = 64,
    parameter int                CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_halt_req,
    input  logic [NUM_FE-1:0]          i_fe_busy,
    input  logic [NUM_RSV-1:0]         i_rsv_busy,
    input  logic [NUM_RSV-1:0]         i_rsv_full,
    input  logic                       i_rob_full,
    input  logic                       i_rob_empty,
    input  logic                       i_dec_valid,
    input  logic [$clog2(NUM_RSV)-1:0] i_dec_rsv_sel,
    input  logic                       i_cm_valid,
    input  logic                       i_cm_mispred,
    input  logic                       i_cm_exc,
    input  logic [PC_W-1:0]            i_cm_target,
    output logic                       o_redir_valid,
    output logic [PC_W-1:0]            o_redir_pc,
    input  logic                       i_redir_ready,
    output logic                       o_fetch_en,
    output logic                       o_dispatch_stall,
    output logic                       o_flush,
    output logic                       o_halted,
    output logic                       o_drain_err,
    output logic [CNT_W-1:0]           o_flush_cnt,
    output logic [CNT_W-1:0]           o_stall_cnt
);

    localparam int TMR_W = $clog2(DRAIN_TMO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDIR,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_HDRAIN,
        S_HALTED
    } state_t;

    state_t             r_state;
    state_t             w_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_redir_valid;
    logic               r_fetch_en;
    logic               r_flush;
    logic               r_halted;
    logic               r_drain_err;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_cm_evt;
    logic               w_all_idle;
    logic               w_in_disp;
    logic               w_stall;
    logic               w_tmo;

    assign w_cm_evt   = i_cm_valid & (i_cm_exc | i_cm_mispred);
    assign w_all_idle = ~|i_fe_busy & ~|i_rsv_busy & i_rob_empty;
    assign w_in_disp  = (r_state == S_RUN) || (r_state == S_HDRAIN);
    assign w_stall    = w_in_disp & (i_rob_full | (i_dec_valid & i_rsv_full[i_dec_rsv_sel]));
    assign w_tmo      = (r_tmr == '0);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_nxt = S_REDIR;
            S_REDIR:  if (i_redir_ready) w_nxt = S_RUN;
            S_RUN: begin
                if (w_cm_evt)        w_nxt = S_FLUSH;
                else if (i_halt_req) w_nxt = S_HDRAIN;
            end
            S_FLUSH:  w_nxt = S_DRAIN;
            S_DRAIN:  if (w_all_idle || w_tmo) w_nxt = S_REDIR;
            S_HDRAIN: begin
                if (w_cm_evt)        w_nxt = S_FLUSH;
                else if (w_all_idle) w_nxt = S_HALTED;
            end
            S_HALTED: if (!i_halt_req) w_nxt = S_REDIR;
            default:  w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_tmr         <= '0;
            r_redir_valid <= 1'b0;
            r_fetch_en    <= 1'b0;
            r_flush       <= 1'b0;
            r_halted      <= 1'b0;
            r_drain_err   <= 1'b0;
            r_flush_cnt   <= '0;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_nxt;
            r_redir_valid <= (w_nxt == S_REDIR);
            r_fetch_en    <= (w_nxt == S_RUN);
            r_flush       <= (w_nxt == S_FLUSH);
            r_halted      <= (w_nxt == S_HALTED);

            if (r_state == S_IDLE && i_start)
                r_pc <= RESET_PC;
            else if (w_in_disp && w_cm_evt)
                r_pc <= i_cm_exc ? EXC_VEC : i_cm_target;

            // Timer counts down from DRAIN_TMO-1; zero marks the last allowed DRAIN cycle.
            if (w_nxt == S_DRAIN && r_state != S_DRAIN)
                r_tmr <= TMR_W'(DRAIN_TMO - 1);
            else if (r_state == S_DRAIN && !w_tmo)
                r_tmr <= r_tmr - TMR_W'(1);

            if (r_state == S_DRAIN && !w_all_idle && w_tmo)
                r_drain_err <= 1'b1;

            if (w_nxt == S_FLUSH && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);

            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_redir_valid    = r_redir_valid;
    assign o_redir_pc       = r_pc;
    assign o_fetch_en       = r_fetch_en;
    assign o_dispatch_stall = w_stall;
    assign o_flush          = r_flush;
    assign o_halted         = r_halted;
    assign o_drain_err      = r_drain_err;
    assign o_flush_cnt      = r_flush_cnt;
    assign o_stall_cnt      = r_stall_cnt;

endmodule
